timer_ctrl: RTL and testbench

Countdown-timer controller for the timer/clock display path. It holds a 4-digit BCD minutes:seconds countdown value and runs the set/run/pause/alarm state machine. It drives the select line of the 4-bit display multiplexer: 0 routes clock digits to the display, 1 routes timer digits. It sits between the debounced button logic and the display mux / 7-segment scanner.

---
 rtl/timer_ctrl.sv | 159 +++++++++++++++
 tb/tb_timer_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Countdown-timer controller: MM:SS BCD value plus IDLE/SET/RUN/PAUSE/ALARM sequencing
// and the clock/timer display select for the 7-segment path.
module timer_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_start,
    input  logic        btn_inc_min,
    input  logic        btn_inc_sec,
    output logic        mux,
    output logic [15:0] tmr_digits,
    output logic        alarm,
    output logic [2:0]  state
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ALARM_SECS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [PW-1:0] pre_q, pre_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [15:0]   dig_d;
    logic [15:0]   dec_val;
    logic          tick;
    logic          any_btn;
    logic          nonzero;

    // One-second BCD decrement with per-digit borrow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = v;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Two-digit BCD increment over 00..59, wrapping to 00.
    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick    = ((cur == S_RUN) || (cur == S_ALARM)) && (pre_q == PW'(TICK_DIV - 1));
    assign any_btn = btn_mode | btn_start | btn_inc_min | btn_inc_sec;
    assign nonzero = (tmr_digits != 16'h0000);
    assign dec_val = bcd_dec(tmr_digits);
    assign state   = cur;

    // Next state, next digits, prescaler and alarm counter.
    always_comb begin
        nxt    = cur;
        dig_d  = tmr_digits;
        pre_d  = '0;
        acnt_d = '0;
        case (cur)
            S_IDLE: begin
                if (btn_start) begin
                    if (nonzero) nxt = S_RUN;
                end else if (btn_mode) begin
                    nxt = S_SET;
                end
            end
            S_SET: begin
                if (btn_start) begin
                    if (nonzero) nxt = S_RUN;
                end else if (btn_mode) begin
                    nxt = S_IDLE;
                end else begin
                    if (btn_inc_sec) dig_d[7:0]  = inc60(tmr_digits[7:0]);
                    if (btn_inc_min) dig_d[15:8] = inc60(tmr_digits[15:8]);
                end
            end
            S_RUN: begin
                if (tick) begin
                    dig_d = dec_val;
                    if (dec_val == 16'h0000) nxt = S_ALARM;
                    else if (btn_start)      nxt = S_PAUSE;
                end else if (btn_start) begin
                    nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    nxt = S_RUN;
                end else if (btn_mode) begin
                    nxt   = S_IDLE;
                    dig_d = 16'h0000;
                end
            end
            S_ALARM: begin
                dig_d = 16'h0000;
                if (any_btn)
                    nxt = S_IDLE;
                else if (tick && (acnt_q == AW'(ALARM_SECS - 1)))
                    nxt = S_IDLE;
            end
            default: begin
                nxt   = S_IDLE;
                dig_d = 16'h0000;
            end
        endcase

        // Any state change restarts the second; only RUN/ALARM advance it.
        if ((nxt == cur) && ((cur == S_RUN) || (cur == S_ALARM)))
            pre_d = tick ? '0 : pre_q + PW'(1);

        if ((cur == S_ALARM) && (nxt == S_ALARM))
            acnt_d = tick ? acnt_q + AW'(1) : acnt_q;
    end

    // State, datapath and Moore output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_IDLE;
            tmr_digits <= 16'h0000;
            pre_q      <= '0;
            acnt_q     <= '0;
            mux        <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            cur        <= nxt;
            tmr_digits <= dig_d;
            pre_q      <= pre_d;
            acnt_q     <= acnt_d;
            mux        <= (nxt != S_IDLE);
            alarm      <= (nxt == S_ALARM);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed button sequences, an integer-seconds reference model
// checked every cycle, and literal expectations at the key points.
module tb_timer_ctrl;

    localparam int TD = 4;
    localparam int AS = 2;

    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] SEC   = 4'b0001;
    localparam logic [3:0] MIN   = 4'b0010;
    localparam logic [3:0] MODE  = 4'b0100;
    localparam logic [3:0] START = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_mode, btn_start, btn_inc_min, btn_inc_sec;
    logic        mux, alarm;
    logic [15:0] tmr_digits;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: state number, minutes, seconds, cycles since entering RUN/ALARM.
    int mst, mmin, msec, mcyc;

    timer_ctrl #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode    (btn_mode),
        .btn_start   (btn_start),
        .btn_inc_min (btn_inc_min),
        .btn_inc_sec (btn_inc_sec),
        .mux         (mux),
        .tmr_digits  (tmr_digits),
        .alarm       (alarm),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd(input int mn, input int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model_reset();
        mst = 0; mmin = 0; msec = 0; mcyc = 0;
    endtask

    task automatic model_step(input logic [3:0] b);
        int  t;
        logic s_, m_, mi, se;
        {s_, m_, mi, se} = b;
        if (!rst_n) begin
            model_reset();
            return;
        end
        t = mmin * 60 + msec;
        case (mst)
            0: if (s_) begin if (t != 0) begin mst = 2; mcyc = 0; end end
               else if (m_) mst = 1;
            1: if (s_) begin if (t != 0) begin mst = 2; mcyc = 0; end end
               else if (m_) mst = 0;
               else begin
                   if (se) msec = (msec + 1) % 60;
                   if (mi) mmin = (mmin + 1) % 60;
               end
            2: if (mcyc % TD == TD - 1) begin
                   t = t - 1; mmin = t / 60; msec = t % 60;
                   if (t == 0) begin mst = 4; mcyc = 0; end
                   else begin mcyc++; if (s_) mst = 3; end
               end else if (s_) mst = 3;
               else mcyc++;
            3: if (s_) begin mst = 2; mcyc = 0; end
               else if (m_) begin mst = 0; mmin = 0; msec = 0; end
            4: if (b != 4'b0000) mst = 0;
               else if (mcyc == AS * TD - 1) mst = 0;
               else mcyc++;
            default: model_reset();
        endcase
    endtask

    // One clock cycle with the given buttons held across the rising edge.
    task automatic step(input logic [3:0] b);
        {btn_start, btn_mode, btn_inc_min, btn_inc_sec} = b;
        @(posedge clk);
        model_step(b);
        #1;
        {btn_start, btn_mode, btn_inc_min, btn_inc_sec} = NONE;
    endtask

    task automatic steps(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",  32'(state),      32'(mst));
            chk("mux",    32'(mux),        32'(mst != 0));
            chk("alarm",  32'(alarm),      32'(mst == 4));
            chk("digits", 32'(tmr_digits), 32'(bcd(mmin, msec)));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        {btn_start, btn_mode, btn_inc_min, btn_inc_sec} = NONE;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_state",  32'(state),      32'd0);
        chk("rst_digits", 32'(tmr_digits), 32'h0000);
        chk("rst_mux",    32'(mux),        32'd0);
        steps(NONE, 2);
        rst_n = 1'b1;

        // Set entry and return to IDLE with digits retained
        step(MODE); step(MIN); steps(SEC, 5);
        chk("set_digits", 32'(tmr_digits), 32'h0105);
        chk("set_state",  32'(state),      32'd1);
        chk("set_mux",    32'(mux),        32'd1);
        step(MODE);
        chk("idle_state",  32'(state),      32'd0);
        chk("idle_mux",    32'(mux),        32'd0);
        chk("idle_digits", 32'(tmr_digits), 32'h0105);

        // First decrement exactly TICK_DIV cycles after RUN entry
        step(START);
        steps(NONE, 3);
        chk("run_pre_tick", 32'(tmr_digits), 32'h0105);
        step(NONE);
        chk("run_0104", 32'(tmr_digits), 32'h0104);
        step(START); step(MODE);
        chk("pause_clear", 32'(tmr_digits), 32'h0000);

        // Borrow 01:00 -> 00:59
        step(MODE); step(MIN); step(START); steps(NONE, 4);
        chk("borrow_0059", 32'(tmr_digits), 32'h0059);
        step(START); step(MODE);

        // Borrow 10:00 -> 09:59
        step(MODE); steps(MIN, 10); step(START); steps(NONE, 4);
        chk("borrow_0959", 32'(tmr_digits), 32'h0959);
        step(START); step(MODE);

        // Expiry and automatic return after ALARM_SECS ticks
        step(MODE); step(SEC); step(START); steps(NONE, 4);
        chk("exp_digits", 32'(tmr_digits), 32'h0000);
        chk("exp_state",  32'(state),      32'd4);
        chk("exp_alarm",  32'(alarm),      32'd1);
        steps(NONE, 7);
        chk("alarm_held", 32'(alarm), 32'd1);
        step(NONE);
        chk("alarm_done_state", 32'(state), 32'd0);
        chk("alarm_done_mux",   32'(mux),   32'd0);
        chk("alarm_done_alarm", 32'(alarm), 32'd0);

        // Final tick beats btn_start; a button then leaves ALARM
        step(MODE); step(SEC); step(START); steps(NONE, 3); step(START);
        chk("tick_wins", 32'(state), 32'd4);
        step(SEC);
        chk("alarm_btn_exit", 32'(state), 32'd0);

        // SET boundaries: wraps without carry, start at zero ignored, start beats mode
        step(MODE); steps(MIN, 59); steps(SEC, 59);
        chk("set_5959", 32'(tmr_digits), 32'h5959);
        step(SEC);
        chk("wrap_sec", 32'(tmr_digits), 32'h5900);
        step(MIN);
        chk("wrap_min", 32'(tmr_digits), 32'h0000);
        step(START);
        chk("start_zero", 32'(state), 32'd1);
        steps(SEC, 30);
        step(START | MODE);
        chk("start_over_mode", 32'(state), 32'd2);
        step(START); step(MODE);

        // Pause discards partial second; resume waits a full TICK_DIV
        step(MODE); steps(SEC, 11); step(START); steps(NONE, 4);
        chk("pause_pre", 32'(tmr_digits), 32'h0010);
        step(NONE); step(START);
        steps(NONE, 20);
        chk("pause_hold_digits", 32'(tmr_digits), 32'h0010);
        chk("pause_hold_state",  32'(state),      32'd3);
        step(START); steps(NONE, 3);
        chk("resume_pre_tick", 32'(tmr_digits), 32'h0010);
        step(NONE);
        chk("resume_0009", 32'(tmr_digits), 32'h0009);
        step(START); step(MODE);
        chk("pause_mode_state",  32'(state),      32'd0);
        chk("pause_mode_digits", 32'(tmr_digits), 32'h0000);

        // Asynchronous reset in the middle of RUN at 00:37
        step(MODE); steps(SEC, 37); step(START); steps(NONE, 2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_state",  32'(state),      32'd0);
        chk("midrst_digits", 32'(tmr_digits), 32'h0000);
        chk("midrst_alarm",  32'(alarm),      32'd0);
        steps(NONE, 2);
        rst_n = 1'b1;
        steps(NONE, 3 * TD);
        chk("post_rst_digits", 32'(tmr_digits), 32'h0000);
        chk("post_rst_state",  32'(state),      32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
